// File: rtl/spi_reg_bank_pkg.sv
// Shared constants and helpers for the SPI configuration register bank.
// Mirrors the access-mode and command-bit definitions used by the SPI decoder.
package spi_reg_bank_pkg;

    typedef enum logic {
        REG_RW = 1'b0,
        REG_RO = 1'b1
    } reg_mode_e;

    // Default position of the transfer-request bit inside the transfer slot.
    localparam int XFER_BIT_POS = 0;

    function automatic reg_mode_e slot_mode(input logic ro_bit);
        return ro_bit ? REG_RO : REG_RW;
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// Access bus between the SPI slave decoder (master) and the register bank (slave).
interface spi_reg_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) ();

    logic              I_enable;
    logic              I_wen;
    logic              I_ren;
    logic [ADDR_W-1:0] I_addr;
    logic [DATA_W-1:0] I_din;
    logic [DATA_W-1:0] O_dout;
    logic              O_rvalid;
    logic              O_addr_err;

    modport master (
        output I_enable, I_wen, I_ren, I_addr, I_din,
        input  O_dout, O_rvalid, O_addr_err
    );

    modport slave (
        input  I_enable, I_wen, I_ren, I_addr, I_din,
        output O_dout, O_rvalid, O_addr_err
    );

endinterface

// File: rtl/spi_reg_cell.sv
// One register slot: master copy, optional shadow (active) copy and a one-cycle update strobe.
module spi_reg_cell
    import spi_reg_bank_pkg::*;
#(
    parameter int              DATA_W   = 8,
    parameter logic [DATA_W-1:0] DEFAULT  = '0,
    parameter bit              SHADOWED = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_i,
    input  logic              xfer_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic [DATA_W-1:0] clr_mask_i,
    output logic [DATA_W-1:0] master_o,
    output logic [DATA_W-1:0] active_o,
    output logic              strobe_o
);

    logic [DATA_W-1:0] master_q, master_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              strobe_q, strobe_d;

    // A write outranks the self-clear so the transfer bit can be re-armed in the copy cycle.
    always_comb begin
        master_d = wr_i ? din_i : (master_q & ~clr_mask_i);
        shadow_d = shadow_q;
        strobe_d = 1'b0;
        if (SHADOWED) begin
            if (xfer_i) begin
                shadow_d = master_q;
                strobe_d = 1'b1;
            end
        end else begin
            strobe_d = wr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            master_q <= DEFAULT;
            shadow_q <= DEFAULT;
            strobe_q <= 1'b0;
        end else begin
            master_q <= master_d;
            shadow_q <= shadow_d;
            strobe_q <= strobe_d;
        end
    end

    assign master_o = master_q;
    assign active_o = SHADOWED ? shadow_q : master_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-addressable configuration register bank with RO slots, shadowed RW slots and
// an atomic transfer command; registered readback and per-slot update strobes.
module spi_reg_bank
    import spi_reg_bank_pkg::*;
#(
    parameter int                       DATA_W        = 8,
    parameter int                       ADDR_W        = 4,
    parameter int                       NUM_REGS      = 16,
    parameter logic [NUM_REGS*DATA_W-1:0] DEFAULT_VALS  = '0,
    parameter logic [NUM_REGS-1:0]      RO_MASK       = '0,
    parameter logic [NUM_REGS-1:0]      SHADOW_MASK   = '0,
    parameter int                       TRANSFER_ADDR = NUM_REGS - 1,
    parameter int                       TRANSFER_BIT  = XFER_BIT_POS
) (
    input  logic                       I_clk,
    input  logic                       I_reset_n,
    spi_reg_bank_if.slave              bus,
    input  logic [NUM_REGS*DATA_W-1:0] I_ro_data,
    output logic [NUM_REGS*DATA_W-1:0] O_regs,
    output logic [NUM_REGS-1:0]        O_upd_strobe
);

    if (TRANSFER_ADDR >= NUM_REGS || TRANSFER_ADDR < 0) begin : g_bad_xfer_addr
        $error("spi_reg_bank: TRANSFER_ADDR %0d outside 0..%0d", TRANSFER_ADDR, NUM_REGS - 1);
    end else if (RO_MASK[TRANSFER_ADDR] || SHADOW_MASK[TRANSFER_ADDR]) begin : g_bad_xfer_mode
        $error("spi_reg_bank: transfer slot %0d must be RW and unshadowed", TRANSFER_ADDR);
    end
    if (NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
        $error("spi_reg_bank: NUM_REGS %0d exceeds address space", NUM_REGS);
    end

    logic [NUM_REGS-1:0] wr_sel;
    logic [DATA_W-1:0]   master_arr [NUM_REGS];
    logic                xfer;
    logic                addr_ok;
    logic                rd_req;
    logic [DATA_W-1:0]   rd_val;

    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                rvalid_q, rvalid_d;
    logic                addr_err_q, addr_err_d;

    // A pending transfer is simply the command bit sitting in master; it fires on the next edge.
    assign xfer    = master_arr[TRANSFER_ADDR][TRANSFER_BIT];
    assign addr_ok = 32'(bus.I_addr) < NUM_REGS;
    assign rd_req  = bus.I_enable & bus.I_ren;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
        localparam bit IS_RO = (slot_mode(RO_MASK[gi]) == REG_RO);
        localparam logic [DATA_W-1:0] CLR_BIT =
            (gi == TRANSFER_ADDR) ? ({{(DATA_W-1){1'b0}}, 1'b1} << TRANSFER_BIT) : '0;

        logic [DATA_W-1:0] active;
        logic              strobe;

        assign wr_sel[gi] = bus.I_enable & bus.I_wen & (bus.I_addr == ADDR_W'(gi)) & ~IS_RO;

        spi_reg_cell #(
            .DATA_W  (DATA_W),
            .DEFAULT (DEFAULT_VALS[gi*DATA_W +: DATA_W]),
            .SHADOWED(SHADOW_MASK[gi] && !IS_RO)
        ) u_cell (
            .clk_i     (I_clk),
            .rst_n_i   (I_reset_n),
            .wr_i      (wr_sel[gi]),
            .xfer_i    (xfer),
            .din_i     (bus.I_din),
            .clr_mask_i(xfer ? CLR_BIT : '0),
            .master_o  (master_arr[gi]),
            .active_o  (active),
            .strobe_o  (strobe)
        );

        assign O_regs[gi*DATA_W +: DATA_W] = active;
        assign O_upd_strobe[gi]            = strobe;
    end

    // Readback shows master (not shadow) for RW slots, live input for RO slots, 0 out of range.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.I_addr == ADDR_W'(i)) begin
                rd_val = RO_MASK[i] ? I_ro_data[i*DATA_W +: DATA_W] : master_arr[i];
            end
        end
    end

    always_comb begin
        dout_d     = rd_req ? rd_val : dout_q;
        rvalid_d   = rd_req;
        addr_err_d = bus.I_enable & (bus.I_wen | bus.I_ren) & ~addr_ok;
    end

    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            dout_q     <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.O_dout     = dout_q;
    assign bus.O_rvalid   = rvalid_q;
    assign bus.O_addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the register bank.
module tb_spi_reg_bank;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 12;
    localparam int XA = 11;
    localparam int XB = 0;
    localparam logic [NR*DW-1:0] DEF = 96'hB6A6_9686_7666_5646_3626_1606;
    localparam logic [NR-1:0]    RO  = 12'h0A0;
    localparam logic [NR-1:0]    SH  = 12'h118;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR*DW-1:0] ro_data;
    logic [NR*DW-1:0] regs;
    logic [NR-1:0]    strobe;

    spi_reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    spi_reg_bank #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .NUM_REGS     (NR),
        .DEFAULT_VALS (DEF),
        .RO_MASK      (RO),
        .SHADOW_MASK  (SH),
        .TRANSFER_ADDR(XA),
        .TRANSFER_BIT (XB)
    ) dut (
        .I_clk       (clk),
        .I_reset_n   (reset_n),
        .bus         (bus),
        .I_ro_data   (ro_data),
        .O_regs      (regs),
        .O_upd_strobe(strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_master [NR];
    logic [DW-1:0] m_active [NR];
    logic [DW-1:0] e_dout;
    logic          e_rvalid;
    logic          e_err;
    logic [NR-1:0] e_strobe;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then compare every output.
    task automatic step(input logic rst_n, input logic en, input logic wen, input logic ren,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        int               ai;
        logic [NR*DW-1:0] exp_regs;
        ai              = int'(a);
        reset_n         = rst_n;
        bus.I_enable    = en;
        bus.I_wen       = wen;
        bus.I_ren       = ren;
        bus.I_addr      = a;
        bus.I_din       = d;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                m_master[i] = DEF[i*DW +: DW];
                m_active[i] = DEF[i*DW +: DW];
            end
            e_dout   = '0;
            e_rvalid = 1'b0;
            e_err    = 1'b0;
            e_strobe = '0;
        end else begin
            e_strobe = '0;
            e_rvalid = en & ren;
            e_err    = en & (wen | ren) & (ai >= NR);
            if (en && ren) begin
                if (ai >= NR)   e_dout = '0;
                else if (RO[ai]) e_dout = ro_data[ai*DW +: DW];
                else             e_dout = m_master[ai];
            end
            if (m_master[XA][XB]) begin
                for (int i = 0; i < NR; i++) begin
                    if (SH[i]) begin
                        m_active[i] = m_master[i];
                        e_strobe[i] = 1'b1;
                    end
                end
                m_master[XA][XB] = 1'b0;
            end
            if (en && wen && ai < NR && !RO[ai]) begin
                m_master[ai] = d;
                if (!SH[ai]) e_strobe[ai] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            exp_regs[i*DW +: DW] = SH[i] ? m_active[i] : m_master[i];
        end
        check("rvalid",   {127'b0, bus.O_rvalid},   {127'b0, e_rvalid});
        check("dout",     {120'b0, bus.O_dout},     {120'b0, e_dout});
        check("addr_err", {127'b0, bus.O_addr_err}, {127'b0, e_err});
        check("strobe",   {116'b0, strobe},         {116'b0, e_strobe});
        check("regs",     {32'b0, regs},            {32'b0, exp_regs});
        $display("step rst_n=%0b en=%0b wen=%0b ren=%0b addr=%0d din=%02h -> dout=%02h rvalid=%0b err=%0b strobe=%03h",
                 rst_n, en, wen, ren, a, d, bus.O_dout, bus.O_rvalid, bus.O_addr_err, strobe);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.I_enable = 1'b0;
        bus.I_wen    = 1'b0;
        bus.I_ren    = 1'b0;
        bus.I_addr   = '0;
        bus.I_din    = '0;
        ro_data      = '0;
        ro_data[5*DW +: DW] = 8'h5A;
        ro_data[7*DW +: DW] = 8'h77;

        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

        // Read every slot after reset, then confirm rvalid drops.
        for (int i = 0; i < NR; i++) step(1'b1, 1'b1, 1'b0, 1'b1, AW'(i), 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

        // Unshadowed write.
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 8'hA5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

        // Shadowed write, readback of master, then transfer.
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 8'h3C);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'(XA), 8'h01);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'(XA), 8'h00);
        check("xfer_slot3", {120'b0, regs[3*DW +: DW]}, {120'b0, 8'h3C});
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'(XA), 8'h00);
        check("xfer_cleared", {120'b0, bus.O_dout}, {120'b0, 8'h00});

        // RO slot ignores writes and reads the live input.
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 8'hFF);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 8'h00);
        check("ro_read", {120'b0, bus.O_dout}, {120'b0, 8'h5A});

        // Out-of-range read and write.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd13, 8'hEE);

        // Read-before-write on the same address.
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 8'h11);
        check("rbw_old", {120'b0, bus.O_dout}, {120'b0, 8'hA5});
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 8'h00);

        // Reset right after a transfer write cancels the copy.
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 8'h99);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'(XA), 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

        // Random traffic, with frequent transfer commands and rare resets.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] a;
            logic          en, wen, ren, rst_n;
            ro_data = {$urandom, $urandom, $urandom};
            en      = ($urandom_range(0, 9) != 0);
            wen     = $urandom_range(0, 1) != 0;
            ren     = $urandom_range(0, 1) != 0;
            a       = ($urandom_range(0, 3) == 0) ? AW'(XA) : AW'($urandom_range(0, 15));
            rst_n   = ($urandom_range(0, 99) != 0);
            step(rst_n, en, wen, ren, a, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
